inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch reader on the consumer side of the program counter.
- Samples the current pc and issues single-outstanding reads to instruction memory over a req/ack + rvalid interface.
- Buffers returned words with their pc in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives pc_stall back to the program counter; on a jump it flushes the FIFO and drops any stale in-flight response.

Parameters:
- DATA_W, 32, instruction and address width
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2
- PTR_W, 2, log2(FIFO_DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  DATA_W  current fetch address from program counter
- jump_reg  in  1  redirect this cycle; the PC loads jump_addr regardless of pc_stall
- jump_addr  in  DATA_W  redirect target (informational; the next pc carries it)
- pc_stall  out  1  hold pc this cycle
- imem_req  out  1  read request
- imem_addr  out  DATA_W  read address
- imem_ack  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  DATA_W  read data
- id_valid  out  1  instruction available to decode
- id_inst  out  DATA_W  instruction word
- id_pc  out  DATA_W  address of id_inst
- id_ready  in  1  decode accepts this cycle

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, FIFO empty.
  - imem_req=0, id_valid=0, imem_addr=0, id_inst=0, id_pc=0, req_pc=0.
  - pc_stall=1.
- FSM states:
  - IDLE: no request in flight.
  - WAIT: accepted request awaiting rvalid.
  - DROP: flushed request awaiting its discarded rvalid.
- Space rule: credit = FIFO_DEPTH − count − (state==WAIT).
- IDLE:
  - imem_req = (credit>0) & ~jump_reg; imem_addr = pc (combinational).
  - On imem_req & imem_ack: req_pc<=pc; go WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid & ~jump_reg: push {req_pc, imem_rdata}; go IDLE.
  - On jump_reg & imem_rvalid (same cycle): discard data; go IDLE.
  - On jump_reg & ~imem_rvalid: go DROP.
- DROP:
  - imem_req=0.
  - On imem_rvalid: discard; go IDLE.
  - jump_reg in DROP keeps DROP.
- pc_stall = ~(imem_req & imem_ack). The PC advances exactly once per accepted request; jump_reg overrides the stall.
- Flush:
  - jump_reg clears the FIFO at the next edge.
  - id_valid is forced 0 combinationally in the jump_reg cycle; any pop requested that cycle is ignored.
- FIFO:
  - Push and pop can occur in the same cycle; count is unchanged.
  - Overflow is impossible by the credit rule.
  - Pointers wrap modulo FIFO_DEPTH.
- Decode side:
  - id_valid = ~empty & ~jump_reg; id_inst/id_pc = head entry.
  - Pop when id_valid & id_ready.
- Latency: rvalid at edge N makes id_valid=1 in cycle N+1 when the FIFO was empty (registered push, no bypass).
- imem_ack is ignored outside IDLE. imem_rvalid in IDLE is a protocol error; data is ignored.

Optional Feature:
- Macro INST_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with pc_stall=1 & ~jump_reg) and perf_flush_cnt[15:0] (jump_reg cycles).
  - Counters saturate; both reset to 0.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines file gains RstEnable-style constants for this block: the FSM state encodings IF_IDLE=2'b00, IF_WAIT=2'b01, IF_DROP=2'b10, plus the default FIFO_DEPTH.
- One sub-module, fetch_fifo: a synchronous FIFO of width 2*DATA_W, parameterised depth, with push, pop, flush, count, and full/empty outputs.
- The FSM and credit logic stay in inst_fetch.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously.
  - Response: imem_req=0, id_valid=0, pc_stall=1 immediately; a later rvalid is ignored.
- Zero-wait memory (ack=1 always, rvalid one cycle after ack, rdata=addr^32'hFFFF0000), pc=0,4,8, id_ready=1:
  - Response: id_pc sequence 0,4,8 with matching id_inst; one request every 2 cycles.
- Backpressure, id_ready=0:
  - Response: after 4 fetches (pc 0..12) count=4, imem_req stays 0, pc_stall=1.
  - Stimulus: raise id_ready for one cycle.
  - Response: exactly one new request, issued in the cycle after the pop.
- Jump while WAIT for pc=8, delay rvalid 3 cycles, jump_addr=0x100:
  - Response: FIFO empties; the delayed rdata is never presented.
  - Response: next id_pc=0x100.
- Jump coincident with rvalid, jump_addr=0x40:
  - Response: that data is discarded; FSM goes directly to IDLE; the next request address is 0x40.
- With INST_FETCH_PERF_EN:
  - Stimulus: 5 backpressured stall cycles and 2 jumps.
  - Response: perf_stall_cnt increases by ≥5; perf_flush_cnt=2.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
// Shared constants for the instruction-fetch block: FSM state encodings
// and the default build-time sizes.
// Optional feature macro for the block: INST_FETCH_PERF_EN.
package inst_fetch_pkg;

  localparam int IF_DATA_W_DEF     = 32;
  localparam int IF_FIFO_DEPTH_DEF = 4;
  localparam int IF_PTR_W_DEF      = 2;

  // IDLE: nothing in flight; WAIT: accepted read awaiting rvalid;
  // DROP: read flushed by a jump, still awaiting its (discarded) rvalid.
  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_WAIT = 2'b01,
    IF_DROP = 2'b10
  } if_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if
// Bundles the instruction-memory read port and the decode handshake.
//   imem_req/imem_addr   : read request and address (fetch -> memory)
//   imem_ack             : request accepted (memory -> fetch)
//   imem_rvalid/rdata    : read response (memory -> fetch)
//   id_valid/inst/pc     : instruction to decode (fetch -> decode)
//   id_ready             : decode accepts (decode -> fetch)
// master = fetch unit side, slave = memory/decode side.
interface inst_fetch_if #(
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic [DATA_W-1:0] id_inst;
  logic [DATA_W-1:0] id_pc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc,
    input  imem_ack, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc,
    output imem_ack, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO holding {pc, instruction} pairs for the fetch unit.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO at the next edge (wins over push/pop)
//   rdata        : head entry
//   count        : number of stored entries (0..DEPTH)
//   full, empty  : occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero before any push;
  // pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
// Instruction-fetch reader: issues single-outstanding reads at the current
// pc, buffers returned words with their pc and hands them to decode.
// Optional feature macro: INST_FETCH_PERF_EN (adds perf counters).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pc              : current fetch address from the program counter
//   jump_reg        : redirect this cycle (flushes buffered/in-flight work)
//   jump_addr       : redirect target, carried by the next pc (not used here)
//   pc_stall        : hold the pc this cycle
//   bus             : imem read port + decode handshake (master side)
//   perf_stall_cnt  : [perf] cycles with pc_stall & ~jump_reg (saturating)
//   perf_flush_cnt  : [perf] jump_reg cycles (saturating)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DATA_W     = IF_DATA_W_DEF,
  parameter int FIFO_DEPTH = IF_FIFO_DEPTH_DEF,
  parameter int PTR_W      = IF_PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic              jump_reg,
  input  logic [DATA_W-1:0] jump_addr,
  output logic              pc_stall,
  inst_fetch_if.master      bus
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W + 2)'(FIFO_DEPTH);

  if_state_e           state;
  logic [DATA_W-1:0]   req_pc;
  logic [PTR_W:0]      count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [2*DATA_W-1:0] head;
  logic [PTR_W+1:0]    used;
  logic                issue;
  logic                accept;
  logic                unused_inputs;

  // Slots already spoken for: buffered entries plus the one in flight.
  // Reserving a slot for the in-flight read is what makes overflow impossible.
  assign used   = {1'b0, count} + (PTR_W + 2)'(state == IF_WAIT);
  assign issue  = ~rst & (state == IF_IDLE) & (used < DEPTH_C) & ~jump_reg;
  assign accept = issue & bus.imem_ack;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = rst ? '0 : ((state == IF_IDLE) ? pc : req_pc);
  assign pc_stall      = ~accept;

  // A response is only kept when it belongs to a live request.
  assign push = (state == IF_WAIT) & bus.imem_rvalid & ~jump_reg;

  // Decode never sees an entry in a jump cycle, so no pop happens then.
  assign bus.id_valid = ~fifo_empty & ~jump_reg;
  assign pop          = bus.id_valid & bus.id_ready;
  assign bus.id_pc    = head[2*DATA_W-1:DATA_W];
  assign bus.id_inst  = head[DATA_W-1:0];

  // jump_addr reaches us through pc; full is covered by the credit check.
  assign unused_inputs = ^{jump_addr, fifo_full};

  fetch_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_pc, bus.imem_rdata}),
    .pop   (pop),
    .flush (jump_reg),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request tracker. A jump during WAIT without data moves to DROP so the
  // stale response is swallowed; a jump with data goes straight to IDLE.
  // rvalid in IDLE is a protocol error and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IF_IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (accept) begin
            req_pc <= pc;
            state  <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (jump_reg)              state <= bus.imem_rvalid ? IF_IDLE : IF_DROP;
          else if (bus.imem_rvalid)  state <= IF_IDLE;
        end
        IF_DROP: begin
          if (bus.imem_rvalid) state <= IF_IDLE;
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

`ifdef INST_FETCH_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall & ~jump_reg & ~&perf_stall_cnt)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (jump_reg & ~&perf_flush_cnt)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
// Directed bench for inst_fetch: reset, zero-wait fetch, backpressure,
// jump during an outstanding read and jump coincident with read data.
// Define INST_FETCH_PERF_EN to also exercise the perf counters.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        jump_reg;
  logic [31:0] jump_addr;
  logic        pc_stall;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_if #(.DATA_W(32)) bus ();

  inst_fetch #(
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .jump_reg  (jump_reg),
    .jump_addr (jump_addr),
    .pc_stall  (pc_stall),
    .bus       (bus)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic j, input logic [31:0] ja,
                               input logic ack, input logic rv, input logic [31:0] rd,
                               input logic rdy);
    pc              = p;
    jump_reg        = j;
    jump_addr       = ja;
    bus.imem_ack    = ack;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.id_ready    = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values, with ack high to show the request is held off.
    rst = 1'b1;
    applyStimulus(32'h0000_1234, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkFlag("rst_req", bus.imem_req, 1'b0);
    checkFlag("rst_idv", bus.id_valid, 1'b0);
    checkFlag("rst_stall", pc_stall, 1'b1);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_inst", bus.id_inst, 32'h0);
    checkOutput("rst_pc", bus.id_pc, 32'h0);
`ifdef INST_FETCH_PERF_EN
    checkOutput("rst_perf_stall", perf_stall_cnt, 32'd0);
    checkOutput("rst_perf_flush", {16'h0, perf_flush_cnt}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Zero-wait memory, decode always ready: one request every 2 cycles.
    applyStimulus(32'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("zw_req0", bus.imem_req, 1'b1);
    checkOutput("zw_addr0", bus.imem_addr, 32'd0);
    checkFlag("zw_stall0", pc_stall, 1'b0);
    tick();
    applyStimulus(32'd4, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd0), 1'b1);
    checkFlag("zw_wait_req", bus.imem_req, 1'b0);
    checkFlag("zw_wait_stall", pc_stall, 1'b1);
    checkFlag("zw_wait_idv", bus.id_valid, 1'b0);
    tick();
    applyStimulus(32'd4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("zw_req1", bus.imem_req, 1'b1);
    checkOutput("zw_addr1", bus.imem_addr, 32'd4);
    checkFlag("zw_idv0", bus.id_valid, 1'b1);
    checkOutput("zw_idpc0", bus.id_pc, 32'd0);
    checkOutput("zw_inst0", bus.id_inst, memWord(32'd0));
    tick();
    applyStimulus(32'd8, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd4), 1'b1);
    checkFlag("zw_popped", bus.id_valid, 1'b0);
    tick();
    applyStimulus(32'd8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("zw_addr2", bus.imem_addr, 32'd8);
    checkOutput("zw_idpc1", bus.id_pc, 32'd4);
    checkOutput("zw_inst1", bus.id_inst, memWord(32'd4));
    tick();
    applyStimulus(32'd12, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd8), 1'b1);
    tick();
    applyStimulus(32'd12, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkFlag("zw_req3", bus.imem_req, 1'b1);
    checkOutput("zw_idpc2", bus.id_pc, 32'd8);
    checkOutput("zw_inst2", bus.id_inst, memWord(32'd8));
    tick();

    // Reset asserted mid-cycle while WAIT with one buffered entry.
    applyStimulus(32'd16, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkFlag("mw_idv_before", bus.id_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkFlag("mw_req", bus.imem_req, 1'b0);
    checkFlag("mw_idv", bus.id_valid, 1'b0);
    checkFlag("mw_stall", pc_stall, 1'b1);
    checkOutput("mw_idpc", bus.id_pc, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(32'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkFlag("mw_post_req", bus.imem_req, 1'b1);
    checkFlag("mw_post_stall", pc_stall, 1'b1);
    tick();
    applyStimulus(32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkFlag("mw_stray_rvalid", bus.id_valid, 1'b0);
    tick();

    // Backpressure: four fetches fill the buffer, then the request stops.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'(4 * k), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkFlag("bp_req", bus.imem_req, 1'b1);
      checkOutput("bp_addr", bus.imem_addr, 32'(4 * k));
      tick();
      applyStimulus(32'(4 * k + 4), 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'(4 * k)), 1'b0);
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      applyStimulus(32'd16, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkFlag("bp_full_req", bus.imem_req, 1'b0);
      checkFlag("bp_full_stall", pc_stall, 1'b1);
      checkOutput("bp_head", bus.id_pc, 32'd0);
      tick();
    end
`ifdef INST_FETCH_PERF_EN
    checkOutput("perf_stall", perf_stall_cnt, 32'd11);
`endif
    applyStimulus(32'd16, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("bp_pop_req", bus.imem_req, 1'b0);
    tick();
    applyStimulus(32'd16, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkFlag("bp_resume_req", bus.imem_req, 1'b1);
    checkOutput("bp_resume_addr", bus.imem_addr, 32'd16);
    checkOutput("bp_head_next", bus.id_pc, 32'd4);
    tick();
    applyStimulus(32'd20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkFlag("bp_single_req", bus.imem_req, 1'b0);
    doReset();

    // Jump while WAIT for pc=8; the response arrives three cycles later.
    applyStimulus(32'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(32'd4, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd0), 1'b1);
    tick();
    applyStimulus(32'd4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(32'd8, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd4), 1'b1);
    tick();
    applyStimulus(32'd8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("jw_addr", bus.imem_addr, 32'd8);
    checkOutput("jw_head", bus.id_pc, 32'd4);
    tick();
    applyStimulus(32'd12, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("jw_jump_idv", bus.id_valid, 1'b0);
    checkFlag("jw_jump_req", bus.imem_req, 1'b0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("jw_flushed", bus.id_valid, 1'b0);
    checkFlag("jw_drop_req", bus.imem_req, 1'b0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'd8), 1'b1);
    checkFlag("jw_drop_req2", bus.imem_req, 1'b0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkFlag("jw_new_req", bus.imem_req, 1'b1);
    checkOutput("jw_new_addr", bus.imem_addr, 32'h100);
    checkFlag("jw_stale_hidden", bus.id_valid, 1'b0);
    tick();
    applyStimulus(32'h104, 1'b0, 32'h0, 1'b1, 1'b1, memWord(32'h100), 1'b1);
    tick();
    applyStimulus(32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkFlag("jw_idv", bus.id_valid, 1'b1);
    checkOutput("jw_idpc", bus.id_pc, 32'h100);
    checkOutput("jw_inst", bus.id_inst, memWord(32'h100));
    tick();

    // Jump coincident with rvalid: data dropped, straight back to IDLE.
    applyStimulus(32'h104, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("jc_addr", bus.imem_addr, 32'h104);
    tick();
    applyStimulus(32'h108, 1'b1, 32'h40, 1'b1, 1'b1, memWord(32'h104), 1'b1);
    checkFlag("jc_jump_idv", bus.id_valid, 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkFlag("jc_req", bus.imem_req, 1'b1);
    checkOutput("jc_addr_next", bus.imem_addr, 32'h40);
    checkFlag("jc_discarded", bus.id_valid, 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkFlag("jc_still_empty", bus.id_valid, 1'b0);
`ifdef INST_FETCH_PERF_EN
    checkOutput("perf_flush", {16'h0, perf_flush_cnt}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
